// File: rtl/axis_frame_len_limit_pkg.sv
// Shared types and payload packing helpers for the frame length limiter and the AXI-Stream FIFO family.
// Payload layout, from the LSB up: tdata, tkeep, tlast, tuser.
package axis_frame_len_limit_pkg;

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } state_e;

  function automatic int unsigned keep_offset(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned last_offset(input int unsigned data_w, input int unsigned keep_w);
    return data_w + keep_w;
  endfunction

  function automatic int unsigned user_offset(input int unsigned data_w, input int unsigned keep_w);
    return data_w + keep_w + 1;
  endfunction

  function automatic int unsigned payload_width(input int unsigned data_w, input int unsigned keep_w,
                                                input int unsigned user_w);
    return data_w + keep_w + 1 + user_w;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry output register for a packed stream payload.
// The upstream ready depends only on whether the skid entry is occupied.
module axis_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             out_free_c;

  // Skid entry fills only when the output is stalled; it drains before new input is taken.
  always_comb begin
    out_free_c   = !out_valid_q || out_ready_i;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (out_ready_i) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (out_free_c) begin
      out_valid_d = in_valid_i;
      if (in_valid_i) begin
        out_data_d = in_data_i;
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/axis_frame_len_limit.sv
// Enforces a run-time maximum frame length in beats; oversize frames are cut and marked bad.
// Optional per-frame statistics counters are enabled with AXIS_FRAME_LEN_LIMIT_STATS_EN.
module axis_frame_len_limit
  import axis_frame_len_limit_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH           = 8,
  parameter bit                     KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int unsigned            KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int unsigned            USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0]  USER_BAD_FRAME_VALUE = USER_WIDTH'(1'b1),
  parameter int unsigned            LEN_WIDTH            = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  cfg_max_len,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_frame_valid,
  output logic                  status_truncated
`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [31:0]           stat_good_frames,
  output logic [31:0]           stat_trunc_frames
`endif
);

  localparam int unsigned KEEP_OFFSET   = keep_offset(DATA_WIDTH);
  localparam int unsigned LAST_OFFSET   = last_offset(DATA_WIDTH, KEEP_WIDTH);
  localparam int unsigned USER_OFFSET   = user_offset(DATA_WIDTH, KEEP_WIDTH);
  localparam int unsigned PAYLOAD_WIDTH = payload_width(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH);
  localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;

  state_e                   state_q, state_d;
  logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]     limit_q, limit_d;
  logic [LEN_WIDTH-1:0]     status_len_q, status_len_d;
  logic                     status_valid_q, status_valid_d;
  logic                     status_trunc_q, status_trunc_d;
  logic [LEN_WIDTH-1:0]     limit_c, beat_n_c;
  logic                     accept_c, at_limit_c;
  logic                     skid_valid_c, skid_ready_c, skid_out_valid_c;
  logic [KEEP_WIDTH-1:0]    keep_in_c;
  logic                     last_in_c;
  logic [USER_WIDTH-1:0]    user_in_c;
  logic [PAYLOAD_WIDTH-1:0] skid_in_c, skid_out_c;

  // The limit is taken from cfg on a frame's first beat (cnt_q == 0) and held until the frame ends.
  always_comb begin
    limit_c    = (cnt_q == '0) ? cfg_max_len : limit_q;
    beat_n_c   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + LEN_WIDTH'(1);
    at_limit_c = (limit_c != '0) && (beat_n_c == limit_c);
    accept_c   = s_axis_tvalid && s_axis_tready;
  end

  assign s_axis_tready = (state_q == DROP) || skid_ready_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS:    if (accept_c && !s_axis_tlast && at_limit_c) state_d = DROP;
      DROP:    if (accept_c && s_axis_tlast) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_comb begin
    skid_valid_c   = 1'b0;
    keep_in_c      = KEEP_ENABLE ? s_axis_tkeep : '1;
    last_in_c      = s_axis_tlast;
    user_in_c      = s_axis_tuser;
    cnt_d          = cnt_q;
    limit_d        = limit_q;
    status_len_d   = status_len_q;
    status_valid_d = 1'b0;
    status_trunc_d = 1'b0;
    case (state_q)
      PASS: begin
        skid_valid_c = s_axis_tvalid;
        if (!s_axis_tlast && at_limit_c) begin
          last_in_c = 1'b1;
          user_in_c = USER_BAD_FRAME_VALUE;
        end
        if (accept_c) begin
          cnt_d   = beat_n_c;
          limit_d = limit_c;
          if (s_axis_tlast || at_limit_c) begin
            cnt_d          = '0;
            status_len_d   = beat_n_c;
            status_valid_d = 1'b1;
            status_trunc_d = !s_axis_tlast;
          end
        end
      end
      default: ;
    endcase
    skid_in_c = {user_in_c, last_in_c, keep_in_c, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      limit_q        <= '0;
      status_len_q   <= '0;
      status_valid_q <= 1'b0;
      status_trunc_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      limit_q        <= limit_d;
      status_len_q   <= status_len_d;
      status_valid_q <= status_valid_d;
      status_trunc_q <= status_trunc_d;
    end
  end

  axis_skid_reg #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (skid_in_c),
    .in_valid_i  (skid_valid_c),
    .in_ready_o  (skid_ready_c),
    .out_data_o  (skid_out_c),
    .out_valid_o (skid_out_valid_c),
    .out_ready_i (m_axis_tready)
  );

  assign m_axis_tvalid      = skid_out_valid_c;
  assign m_axis_tdata       = skid_out_c[DATA_WIDTH-1:0];
  assign m_axis_tkeep       = skid_out_c[KEEP_OFFSET +: KEEP_WIDTH];
  assign m_axis_tlast       = skid_out_c[LAST_OFFSET];
  assign m_axis_tuser       = skid_out_c[USER_OFFSET +: USER_WIDTH];
  assign status_frame_len   = status_len_q;
  assign status_frame_valid = status_valid_q;
  assign status_truncated   = status_trunc_q;

`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
  logic [31:0] good_q, trunc_q;

  // Counters follow the registered status pulses; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      good_q  <= '0;
      trunc_q <= '0;
    end else if (status_valid_q) begin
      if (status_trunc_q) begin
        trunc_q <= trunc_q + 32'(1);
      end else begin
        good_q <= good_q + 32'(1);
      end
    end
  end

  assign stat_good_frames  = good_q;
  assign stat_trunc_frames = trunc_q;
`endif

endmodule

// File: tb/tb_axis_frame_len_limit.sv
// Directed and randomised-backpressure bench for axis_frame_len_limit (default 8-bit configuration).
`timescale 1ns/1ps
module tb_axis_frame_len_limit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic [0:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic [0:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic [15:0] cfg_max_len;
  logic [15:0] status_frame_len;
  logic        status_frame_valid;
  logic        status_truncated;
`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_good_frames;
  logic [31:0] stat_trunc_frames;
`endif

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [9:0]  out_q[$];
  logic [9:0]  exp_q[$];
  int          out_cyc_q[$];
  int          acc_cyc_q[$];
  logic [15:0] st_len_q[$];
  int          n_stat = 0;
  int          n_trunc = 0;
  int          stable_viol = 0;
  logic        hold_v = 1'b0;
  logic [9:0]  hold_p = '0;
  int          total, nfr, ntr, mis;
  logic        done;

  axis_frame_len_limit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tuser       (m_axis_tuser),
    .cfg_max_len        (cfg_max_len),
    .status_frame_len   (status_frame_len),
    .status_frame_valid (status_frame_valid),
    .status_truncated   (status_truncated)
`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
    ,
    .stat_clear         (stat_clear),
    .stat_good_frames   (stat_good_frames),
    .stat_trunc_frames  (stat_trunc_frames)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output/status monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (hold_v && (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser} !== hold_p))
      stable_viol++;
    hold_v = m_axis_tvalid && !m_axis_tready;
    hold_p = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    if (m_axis_tvalid && m_axis_tready) begin
      out_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
      out_cyc_q.push_back(cyc);
    end
    if (status_frame_valid) begin
      n_stat++;
      st_len_q.push_back(status_frame_len);
    end
    if (status_truncated) n_trunc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    out_q.delete();
    exp_q.delete();
    out_cyc_q.delete();
    acc_cyc_q.delete();
    st_len_q.delete();
    n_stat  = 0;
    n_trunc = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    logic rdy;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rdy = s_axis_tready;
      step();
      if (rdy) begin
        acc_cyc_q.push_back(cyc);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    s_axis_tvalid = 1'b0;
  endtask

  // Sends a frame and queues the beats a length limiter must emit for it.
  task automatic send_frame(input int len, input int lim, input logic [7:0] d0,
                            input logic [15:0] um, input int mid_cfg);
    logic lst, usr;
    cfg_max_len = 16'(lim);
    for (int i = 0; i < len; i++) begin
      send_beat(d0 + 8'(i), (i == len - 1), um[i]);
      if (i == 0 && mid_cfg >= 0) cfg_max_len = 16'(mid_cfg);
      if (lim == 0 || i < lim) begin
        lst = (i == len - 1) || (lim != 0 && i == lim - 1);
        usr = (lim != 0 && i == lim - 1 && len > lim) ? 1'b1 : um[i];
        exp_q.push_back({d0 + 8'(i), lst, usr});
      end
    end
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int i = 0; i < 400 && out_q.size() < n; i++) step();
    repeat (3) step();
    check(tag, 32'(out_q.size()), 32'(n));
  endtask

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;
    cfg_max_len   = '0;
    done          = 1'b0;
`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
    stat_clear    = 1'b0;
`endif
    repeat (3) step();
    check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_stat_valid", 32'(status_frame_valid), 32'd0);
    check("rst_trunc", 32'(status_truncated), 32'd0);
    check("rst_len", 32'(status_frame_len), 32'd0);
    check("rst_s_ready", 32'(s_axis_tready), 32'd1);
    rst_n = 1'b1;
    step();

    // No limit, 5-beat frame
    clear_q();
    send_frame(5, 0, 8'h10, 16'h0000, -1);
    wait_out("t1_count", 5);
    for (int i = 0; i < 5; i++)
      if (i < out_q.size())
        check($sformatf("t1_beat%0d", i), 32'(out_q[i]), 32'({8'h10 + 8'(i), (i == 4), 1'b0}));
    check("t1_latency", 32'(out_cyc_q[0]), 32'(acc_cyc_q[0]));
    check("t1_in_tput", 32'(acc_cyc_q[4] - acc_cyc_q[0]), 32'd4);
    check("t1_out_tput", 32'(out_cyc_q[4] - out_cyc_q[0]), 32'd4);
    check("t1_stat_n", 32'(n_stat), 32'd1);
    check("t1_len", 32'(st_len_q[0]), 32'd5);
    check("t1_trunc", 32'(n_trunc), 32'd0);
    check("t1_tkeep", 32'(m_axis_tkeep), 32'd1);

    // Limit 4, 7-beat frame is cut at beat 4
    clear_q();
    send_frame(7, 4, 8'h20, 16'h0000, -1);
    wait_out("t2_count", 4);
    for (int i = 0; i < 4; i++)
      if (i < out_q.size())
        check($sformatf("t2_beat%0d", i), 32'(out_q[i]), 32'({8'h20 + 8'(i), (i == 3), (i == 3)}));
    check("t2_drop_tput", 32'(acc_cyc_q[6] - acc_cyc_q[0]), 32'd6);
    check("t2_trunc", 32'(n_trunc), 32'd1);
    check("t2_len", 32'(st_len_q[0]), 32'd4);

    // Following frame passes normally
    clear_q();
    send_frame(3, 4, 8'h30, 16'h0005, -1);
    wait_out("t2b_count", 3);
    check("t2b_beat0", 32'(out_q[0]), 32'({8'h30, 1'b0, 1'b1}));
    check("t2b_beat2", 32'(out_q[2]), 32'({8'h32, 1'b1, 1'b1}));
    check("t2b_trunc", 32'(n_trunc), 32'd0);
    check("t2b_len", 32'(st_len_q[0]), 32'd3);

    // tlast exactly on the limit beat is not truncation
    clear_q();
    send_frame(4, 4, 8'h40, 16'h0002, -1);
    wait_out("t3_count", 4);
    check("t3_beat1", 32'(out_q[1]), 32'({8'h41, 1'b0, 1'b1}));
    check("t3_beat3", 32'(out_q[3]), 32'({8'h43, 1'b1, 1'b0}));
    check("t3_trunc", 32'(n_trunc), 32'd0);
    check("t3_len", 32'(st_len_q[0]), 32'd4);

    // Limit 1 with output stalled: rest of frame still drains from input
    clear_q();
    m_axis_tready = 1'b0;
    send_frame(3, 1, 8'h50, 16'h0000, -1);
    check("l1_drop_while_stalled", 32'(acc_cyc_q[2] - acc_cyc_q[0]), 32'd2);
    check("l1_hold", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
          32'({1'b1, 8'h50, 1'b1, 1'b1}));
    m_axis_tready = 1'b1;
    wait_out("l1_count", 1);
    check("l1_beat", 32'(out_q[0]), 32'({8'h50, 1'b1, 1'b1}));
    check("l1_len", 32'(st_len_q[0]), 32'd1);
    check("l1_trunc", 32'(n_trunc), 32'd1);

    // cfg change mid-frame only affects the next frame
    clear_q();
    send_frame(4, 2, 8'h60, 16'h0000, 0);
    wait_out("mid_cfg_count", 2);
    check("mid_cfg_beat1", 32'(out_q[1]), 32'({8'h61, 1'b1, 1'b1}));
    check("mid_cfg_trunc", 32'(n_trunc), 32'd1);

    // Random backpressure over mixed frame lengths
    clear_q();
    total = 0;
    nfr   = 0;
    ntr   = 0;
    fork
      begin
        while (total < 1000) begin
          int len;
          len = int'($urandom_range(1, 9));
          send_frame(len, 6, 8'($urandom), 16'($urandom), -1);
          total += len;
          nfr++;
          if (len > 6) ntr++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_out("rand_count", exp_q.size());
    mis = 0;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) mis++;
    check("rand_beats", 32'(mis), 32'd0);
    check("rand_stat_n", 32'(n_stat), 32'(nfr));
    check("rand_trunc_n", 32'(n_trunc), 32'(ntr));
    check("stable_while_stalled", 32'(stable_viol), 32'd0);

    // Reset mid-frame abandons it
    send_beat(8'h70, 1'b0, 1'b0);
    cfg_max_len = 16'd4;
    send_beat(8'h70, 1'b0, 1'b0);
    send_beat(8'h71, 1'b0, 1'b0);
    send_beat(8'h72, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    check("mid_rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_len", 32'(status_frame_len), 32'd0);
    rst_n = 1'b1;
    clear_q();
    send_frame(4, 4, 8'h80, 16'h0000, -1);
    wait_out("post_rst_count", 4);
    check("post_rst_beat3", 32'(out_q[3]), 32'({8'h83, 1'b1, 1'b0}));
    check("post_rst_len", 32'(st_len_q[0]), 32'd4);
    check("post_rst_trunc", 32'(n_trunc), 32'd0);

`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    step();
    check("stat_clr_good0", stat_good_frames, 32'd0);
    send_frame(1, 2, 8'h90, 16'h0000, -1);
    send_frame(2, 2, 8'h91, 16'h0000, -1);
    send_frame(3, 2, 8'h93, 16'h0000, -1);
    send_frame(4, 2, 8'h96, 16'h0000, -1);
    send_frame(2, 2, 8'h9a, 16'h0000, -1);
    repeat (5) step();
    check("stat_good", stat_good_frames, 32'd3);
    check("stat_trunc", stat_trunc_frames, 32'd2);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check("stat_clr_good", stat_good_frames, 32'd0);
    check("stat_clr_trunc", stat_trunc_frames, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
